// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter run controller.
// State encoding and direction constants used by counter_seq_ctrl.
package counter_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle between the switch front end (master) and the run controller (slave).
interface counter_seq_ctrl_if #(
   parameter int unsigned WIDTH = 4
);

   logic             start;
   logic             stop;
   logic             sw;
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] target_val;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;

   modport master (
      output start, stop, sw, start_val, target_val,
      input  q, busy, done
   );

   modport slave (
      input  start, stop, sw, start_val, target_val,
      output q, busy, done
   );

endinterface

// File: rtl/tick_gen.sv
// Prescale counter: pulses tick once every PRESCALE enabled cycles, restarts on clr_cnt.
module tick_gen #(
   parameter int unsigned PRESCALE   = 1,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic clk,
   input  logic CLR,
   input  logic clr_cnt,
   input  logic en,
   output logic tick
);

   localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

   logic [PRESCALE_W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         cnt <= '0;
      end else if (clr_cnt) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run controller for the up/down counter: load, step at prescaled rate, stop on target, flag done.
// Optional macro COUNTER_SEQ_AUTORELOAD_EN makes DONE reload and restart the run.
module counter_seq_ctrl #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned PRESCALE   = 1,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic              clk,
   input  logic              CLR,
   counter_seq_ctrl_if.slave bus
);

   import counter_seq_pkg::*;

   state_t           state;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_step;
   logic             dir;
   logic             busy_r;
   logic             done_r;
   logic             tick;
   logic             clr_cnt;
   logic             en;
   logic             load_hit;

   assign q_step   = (dir == DIR_DOWN) ? q_r - WIDTH'(1) : q_r + WIDTH'(1);
   assign load_hit = (bus.start_val == bus.target_val);

   // Prescaler only runs in RUN; a stop cycle must not advance it.
   assign clr_cnt = (state != ST_RUN);
   assign en      = (state == ST_RUN) && !bus.stop;

   tick_gen #(
      .PRESCALE   (PRESCALE),
      .PRESCALE_W (PRESCALE_W)
   ) u_tick_gen (
      .clk     (clk),
      .CLR     (CLR),
      .clr_cnt (clr_cnt),
      .en      (en),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         state  <= ST_IDLE;
         q_r    <= '0;
         dir    <= DIR_UP;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start && !bus.stop) begin
                  q_r    <= bus.start_val;
                  dir    <= bus.sw;
                  state  <= load_hit ? ST_DONE : ST_RUN;
                  busy_r <= !load_hit;
                  done_r <= load_hit;
               end
            end
            ST_RUN: begin
               if (bus.stop) begin
                  state  <= ST_IDLE;
                  busy_r <= 1'b0;
                  done_r <= 1'b0;
               end else if (tick) begin
                  q_r <= q_step;
                  if (q_step == bus.target_val) begin
                     state  <= ST_DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (bus.stop) begin
                  state  <= ST_IDLE;
                  busy_r <= 1'b0;
                  done_r <= 1'b0;
               end else begin
`ifdef COUNTER_SEQ_AUTORELOAD_EN
                  q_r    <= bus.start_val;
                  dir    <= bus.sw;
                  state  <= load_hit ? ST_DONE : ST_RUN;
                  busy_r <= !load_hit;
                  done_r <= load_hit;
`else
                  state  <= ST_IDLE;
                  busy_r <= 1'b0;
                  done_r <= 1'b0;
`endif
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.q    = q_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

endmodule
